// File: rtl/fp_pkg.sv
// Shared types and width helpers for the sequential floating-point add/sub unit.
package fp_pkg;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fclass_t;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  function automatic int fp_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // hidden + fraction + guard + round + sticky
  function automatic int fp_sig_w(input int man_w);
    return man_w + 4;
  endfunction

  // Canonical quiet NaN, right-aligned in a wide vector: sign 0, exp all ones, frac MSB only.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports N.
module fp_lzc #(
  parameter int N  = 28,
  parameter int CW = $clog2(N + 1)
)(
  input  logic [N-1:0]  x,
  output logic [CW-1:0] cnt
);

  // Highest set bit is visited last, so it wins.
  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++)
      if (x[i]) cnt = CW'(N - 1 - i);
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP adder/subtractor: one state per cycle, RNE rounding, FTZ, IEEE specials.
module fp_addsub_seq import fp_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done,
  output logic                   busy,
  output logic                   flag_invalid,
  output logic                   flag_overflow,
  output logic                   flag_inexact
);

  localparam int W       = fp_w(EXP_W, MAN_W);
  localparam int EXP_MAX = fp_exp_max(EXP_W);
  localparam int SIG_W   = fp_sig_w(MAN_W);
  localparam int EW      = EXP_W + 2;
  localparam int LZW     = $clog2(SIG_W + 2);
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  function automatic fclass_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)      return ZERO;
    else if (e == '1) return (f != '0) ? NAN : INF;
    else              return NORMAL;
  endfunction

  state_t               state;
  logic [W-1:0]         ra, rb;
  logic                 ua_s, ub_s;
  logic [EXP_W-1:0]     ua_e, ub_e;
  logic [MAN_W:0]       ua_m, ub_m;
  fclass_t              ua_c, ub_c;
  logic                 al_sign, al_sub;
  logic [EXP_W-1:0]     al_exp;
  logic [SIG_W-1:0]     al_big, al_small;
  logic                 sp_val, sp_inv;
  logic [W-1:0]         sp_res;
  logic                 ad_sign;
  logic [EXP_W-1:0]     ad_exp;
  logic [SIG_W:0]       ad_sum;
  logic                 nm_sign, nm_zero, nm_inx;
  logic signed [EW-1:0] nm_exp;
  logic [SIG_W-1:0]     nm_sig;

  // ALIGN: order by magnitude, shift the smaller with sticky collection
  logic                 c_big_s, c_sub, c_sp_val, c_sp_inv;
  logic [EXP_W-1:0]     c_big_e, c_diff;
  logic [MAN_W:0]       c_big_m, c_small_m;
  logic [SIG_W-1:0]     c_ext, c_sh, c_mask, c_small;
  logic [W-1:0]         c_sp_res;

  always_comb begin
    c_sub = ua_s ^ ub_s;
    if ({ua_e, ua_m} >= {ub_e, ub_m}) begin
      c_big_s = ua_s; c_big_e = ua_e; c_big_m = ua_m; c_small_m = ub_m; c_diff = ua_e - ub_e;
    end else begin
      c_big_s = ub_s; c_big_e = ub_e; c_big_m = ub_m; c_small_m = ua_m; c_diff = ub_e - ua_e;
    end
    c_ext  = {c_small_m, 3'b000};
    c_sh   = c_ext >> c_diff;
    c_mask = ~({SIG_W{1'b1}} << c_diff);
    if (int'(c_diff) >= MAN_W + 3) c_small = {{(SIG_W-1){1'b0}}, |c_small_m};
    else                           c_small = {c_sh[SIG_W-1:1], c_sh[0] | (|(c_ext & c_mask))};

    c_sp_val = 1'b1; c_sp_inv = 1'b0; c_sp_res = '0;
    if (ua_c == NAN || ub_c == NAN) begin
      c_sp_inv = 1'b1; c_sp_res = QNAN;
    end else if (ua_c == INF && ub_c == INF) begin
      if (c_sub) begin c_sp_inv = 1'b1; c_sp_res = QNAN; end
      else c_sp_res = {ua_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ua_c == INF) c_sp_res = {ua_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (ub_c == INF)     c_sp_res = {ub_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (ua_c == ZERO && ub_c == ZERO) c_sp_res = {ua_s & ub_s, {(W-1){1'b0}}};
    else c_sp_val = 1'b0;
  end

  // NORM: carry right-shift or single-cycle leading-zero left shift
  logic [LZW-1:0]       lz, n_sh;
  logic [SIG_W-1:0]     n_sig;
  logic signed [EW-1:0] n_exp;
  logic                 n_zero, n_ftz;

  fp_lzc #(.N(SIG_W + 1), .CW(LZW)) u_lzc (.x(ad_sum), .cnt(lz));

  always_comb begin
    n_sh = lz - LZW'(1);
    if (ad_sum[SIG_W]) begin
      n_sig = {ad_sum[SIG_W:2], ad_sum[1] | ad_sum[0]};
      n_exp = {2'b00, ad_exp} + EW'(1);
    end else begin
      n_sig = ad_sum[SIG_W-1:0] << n_sh;
      n_exp = {2'b00, ad_exp} - EW'(n_sh);
    end
    n_zero = (ad_sum == '0);
    n_ftz  = !n_zero && (n_exp[EW-1] || n_exp == '0);
  end

  // ROUND: nearest-even on G/R/S, then overflow and special overrides
  logic [MAN_W+1:0]     r_m;
  logic signed [EW-1:0] r_exp;
  logic [W-1:0]         r_res;
  logic                 r_grs, r_inv, r_ovf, r_inx;

  always_comb begin
    r_grs = |nm_sig[2:0];
    r_m   = {1'b0, nm_sig[SIG_W-1:3]}
          + (MAN_W+2)'(nm_sig[2] & (nm_sig[1] | nm_sig[0] | nm_sig[3]));
    r_exp = nm_exp + EW'(r_m[MAN_W+1]);
    r_inv = 1'b0; r_ovf = 1'b0; r_inx = r_grs;
    r_res = {nm_sign, r_exp[EXP_W-1:0], r_m[MAN_W+1] ? r_m[MAN_W:1] : r_m[MAN_W-1:0]};
    if (nm_zero) begin
      r_res = {nm_sign, {(W-1){1'b0}}};
      r_inx = nm_inx;
    end else if (!r_exp[EW-1] && r_exp >= EW'(EXP_MAX)) begin
      r_res = {nm_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_ovf = 1'b1; r_inx = 1'b1;
    end
    if (sp_val) begin
      r_res = sp_res; r_inv = sp_inv; r_ovf = 1'b0; r_inx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0; result <= '0;
      flag_invalid <= 1'b0; flag_overflow <= 1'b0; flag_inexact <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= {b[W-1] ^ op, b[W-2:0]};
          busy <= 1'b1;
          state <= UNPACK;
        end
        UNPACK: begin
          // exp==0 covers both zero and subnormal: flushed to signed zero
          ua_s <= ra[W-1]; ua_c <= classify(ra[W-2:MAN_W], ra[MAN_W-1:0]);
          ub_s <= rb[W-1]; ub_c <= classify(rb[W-2:MAN_W], rb[MAN_W-1:0]);
          ua_e <= ra[W-2:MAN_W];
          ub_e <= rb[W-2:MAN_W];
          ua_m <= (ra[W-2:MAN_W] == '0) ? '0 : {1'b1, ra[MAN_W-1:0]};
          ub_m <= (rb[W-2:MAN_W] == '0) ? '0 : {1'b1, rb[MAN_W-1:0]};
          state <= ALIGN;
        end
        ALIGN: begin
          al_sign <= c_big_s; al_sub <= c_sub; al_exp <= c_big_e;
          al_big <= {c_big_m, 3'b000}; al_small <= c_small;
          sp_val <= c_sp_val; sp_inv <= c_sp_inv; sp_res <= c_sp_res;
          state <= ADD;
        end
        ADD: begin
          ad_sign <= al_sign; ad_exp <= al_exp;
          ad_sum <= al_sub ? {1'b0, al_big} - {1'b0, al_small}
                           : {1'b0, al_big} + {1'b0, al_small};
          state <= NORM;
        end
        NORM: begin
          // exact cancellation gives +0; underflow keeps its sign
          nm_sign <= n_zero ? 1'b0 : ad_sign;
          nm_zero <= n_zero | n_ftz;
          nm_inx  <= n_ftz;
          nm_exp  <= n_exp;
          nm_sig  <= n_sig;
          state <= ROUND;
        end
        ROUND: begin
          result <= r_res;
          flag_invalid <= r_inv; flag_overflow <= r_ovf; flag_inexact <= r_inx;
          done <= 1'b1; busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq at default single-precision widths.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b, result;
  logic        done, busy, flag_invalid, flag_overflow, flag_inexact;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] r;
    logic inv, ovf, inx;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic op;
    logic [31:0] r;
    logic inv, ovf, inx;
  } vec_t;

  exp_t sb_q[$];

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .done(done), .busy(busy),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_inexact(flag_inexact)
  );

  always #5 clk = ~clk;

  // One-cycle start pulse; returns just after the sampling edge.
  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic top);
    @(negedge clk);
    a = ta; b = tb; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges after the start edge until done; -1 if it never arrives.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 20);
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({result, done, busy, flag_invalid, flag_overflow, flag_inexact} !== 37'h0) begin
      miscompares++;
      $display("FAIL reset: got result=%h done=%b busy=%b flags=%b%b%b, want all 0",
               result, done, busy, flag_invalid, flag_overflow, flag_inexact);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    int   lat;
    int   busy_cnt;
    exp_t e;
    sb_q.push_back('{32'h40400000, 1'b0, 1'b0, 1'b0});
    drive(32'h3F800000, 32'h40000000, 1'b0);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end while (!done && lat < 20);
    e = sb_q.pop_front();
    vectors++;
    if (lat != 5 || busy_cnt != 5) begin
      miscompares++;
      $display("FAIL basic timing: got done at edge +%0d busy %0d cycles, want +5 and 5", lat, busy_cnt);
    end
    vectors++;
    if ({result, flag_invalid, flag_overflow, flag_inexact} !== {e.r, e.inv, e.ovf, e.inx}) begin
      miscompares++;
      $display("FAIL basic result: got %h %b%b%b want %h %b%b%b", result,
               flag_invalid, flag_overflow, flag_inexact, e.r, e.inv, e.ovf, e.inx);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic pulse: got done=%b busy=%b after pulse, want 0 0", done, busy);
    end
  endtask

  task automatic test_arith();
    vec_t v[10] = '{
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0},
      '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0},
      '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0},
      '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, 1'b0, 1'b0},
      '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0},
      '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0},
      '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1},
      '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 1'b0},
      '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b0}
    };
    int   lat;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back('{v[i].r, v[i].inv, v[i].ovf, v[i].inx});
      drive(v[i].a, v[i].b, v[i].op);
      wait_done(lat);
      e = sb_q.pop_front();
      vectors++;
      if (lat != 5 || {result, flag_invalid, flag_overflow, flag_inexact} !== {e.r, e.inv, e.ovf, e.inx}) begin
        miscompares++;
        $display("FAIL arith[%0d]: got %h %b%b%b lat %0d want %h %b%b%b lat 5", i, result,
                 flag_invalid, flag_overflow, flag_inexact, lat, e.r, e.inv, e.ovf, e.inx);
      end
    end
  endtask

  task automatic test_special();
    vec_t v[6] = '{
      '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0, 1'b0},
      '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0, 1'b0},
      '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 1'b0},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0, 1'b0},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b1}
    };
    int   lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{v[i].r, v[i].inv, v[i].ovf, v[i].inx});
      drive(v[i].a, v[i].b, v[i].op);
      wait_done(lat);
      e = sb_q.pop_front();
      vectors++;
      if (lat != 5 || {result, flag_invalid, flag_overflow, flag_inexact} !== {e.r, e.inv, e.ovf, e.inx}) begin
        miscompares++;
        $display("FAIL special[%0d]: got %h %b%b%b lat %0d want %h %b%b%b lat 5", i, result,
                 flag_invalid, flag_overflow, flag_inexact, lat, e.r, e.inv, e.ovf, e.inx);
      end
    end
  endtask

  task automatic test_round();
    vec_t v[4] = '{
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1},
      '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1},
      '{32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1},
      '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b1}
    };
    int   lat;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{v[i].r, v[i].inv, v[i].ovf, v[i].inx});
      drive(v[i].a, v[i].b, v[i].op);
      wait_done(lat);
      e = sb_q.pop_front();
      vectors++;
      if (lat != 5 || {result, flag_invalid, flag_overflow, flag_inexact} !== {e.r, e.inv, e.ovf, e.inx}) begin
        miscompares++;
        $display("FAIL round[%0d]: got %h %b%b%b lat %0d want %h %b%b%b lat 5", i, result,
                 flag_invalid, flag_overflow, flag_inexact, lat, e.r, e.inv, e.ovf, e.inx);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    sb_q.push_back('{32'h40400000, 1'b0, 1'b0, 1'b0});
    drive(32'h3F800000, 32'h40000000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 32'h7F800000; b = 32'hFF800000; op = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    vectors++;
    if (dones != 1 || result !== sb_q[0].r || flag_invalid !== sb_q[0].inv) begin
      miscompares++;
      $display("FAIL busy_ignore: got %0d dones result %h inv %b, want 1 done result %h inv %b",
               dones, result, flag_invalid, sb_q[0].r, sb_q[0].inv);
    end
    void'(sb_q.pop_front());
  endtask

  task automatic test_reset_abort();
    int   dones = 0;
    int   lat;
    exp_t e;
    drive(32'h3F800000, 32'h40000000, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    vectors++;
    if (dones != 0 || {result, busy, flag_invalid, flag_overflow, flag_inexact} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_abort: got %0d dones result %h busy %b flags %b%b%b, want none and all 0",
               dones, result, busy, flag_invalid, flag_overflow, flag_inexact);
    end
    sb_q.push_back('{32'h40400000, 1'b0, 1'b0, 1'b0});
    drive(32'h40000000, 32'h3F800000, 1'b0);
    wait_done(lat);
    e = sb_q.pop_front();
    vectors++;
    if (lat != 5 || {result, flag_invalid, flag_overflow, flag_inexact} !== {e.r, e.inv, e.ovf, e.inx}) begin
      miscompares++;
      $display("FAIL after_reset: got %h lat %0d want %h lat 5", result, lat, e.r);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    sb_q.push_back('{32'h40000000, 1'b0, 1'b0, 1'b0});
    sb_q.push_back('{32'h40800000, 1'b0, 1'b0, 1'b0});
    drive(32'h3F800000, 32'h3F800000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_done(lat);
      e = sb_q.pop_front();
      vectors++;
      if (lat != 5 || {result, flag_invalid, flag_overflow, flag_inexact} !== {e.r, e.inv, e.ovf, e.inx}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h lat %0d want %h lat 5", k, result, lat, e.r);
      end
      if (k == 0) drive(32'h40400000, 32'h3F800000, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_special();
    test_round();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Parametrised sequential IEEE-754-style floating-point adder/subtractor with a start/done handshake and fixed latency. It generalises the team's single-precision adder:
- configurable exponent and fraction widths
- add/subtract mode
- round-to-nearest-even using guard/round/sticky bits
- full special-case handling and exception flags

It sits beside the datapath as a shared arithmetic unit issued one operation at a time.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width (>=2); total word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
op  in  1  0 = a+b, 1 = a-b (b sign inverted at capture)
a  in  W  operand A
b  in  W  operand B
result  out  W  packed result, held until next done
done  out  1  one-cycle pulse, result valid
busy  out  1  high while an operation is in flight
flag_invalid  out  1  inf-inf or NaN operand; valid with done, held
flag_overflow  out  1  rounded result exceeded max finite; held
flag_inexact  out  1  any nonzero guard/round/sticky discarded; held

Behaviour:
- Reset (clk is clk, reset is synchronous active-high): state=IDLE; result=0, done=0, busy=0, all flags=0. Reset mid-operation aborts it, no done is produced, and start in the reset cycle is ignored.
- FSM states and transitions:
  - IDLE → UNPACK on start: operands and op captured.
  - UNPACK → ALIGN → ADD → NORM → ROUND → IDLE.
  - Exactly one state per cycle.
- Latency: if start is sampled at edge N, done=1 and result/flags update at edge N+5. busy is high from edge N to N+5. Fixed latency, special cases included.
- start while busy=1 is ignored, with no queueing. start on the cycle done pulses (busy already low after N+5) is accepted.
- UNPACK:
  - Subnormal inputs (exp=0) flush to signed zero (FTZ).
  - Hidden bit is prepended.
  - Classify each operand as zero, inf or NaN.
- ALIGN:
  - Swap so the larger magnitude is the first operand.
  - Right-shift the smaller by the exponent difference into an MAN_W+4-bit field (hidden, fraction, G, R), with a sticky bit S = OR of all bits shifted out.
  - Shifts >= MAN_W+3 saturate: field = 0, S = OR of the whole significand.
- ADD: effective subtraction when the signs differ. Result sign = sign of the larger magnitude. Carry-out is kept (MAN_W+5 bits).
- NORM:
  - On carry-out, right-shift 1 (sticky absorbs the LSB), exp+1.
  - Otherwise, left-shift by the leading-zero count in a single cycle, with exp decreased accordingly.
  - If exp would go <= 0, result flushes to signed zero (FTZ), and inexact is set if the value was nonzero.
- ROUND:
  - RNE: increment if G & (R | S | LSB).
  - Mantissa overflow after increment → shift, exp+1.
  - exp >= 2^EXP_W-1 → ±inf, flag_overflow=1, flag_inexact=1.
- Special cases (override the datapath; flags reflect them):
  - Any NaN operand → canonical qNaN: sign 0, exp all ones, fraction MSB 1 only. flag_invalid=1.
  - inf + (-inf) effective → canonical qNaN, flag_invalid=1.
  - Single inf → that inf with its effective sign.
  - Exact zero sum of opposite-sign operands → +0.
  - (-0)+(-0) → -0.
  - x + 0 → x, exact.
- Flags are registered and replaced at each done; they are not sticky across operations.

Decomposition:
- Package fp_pkg:
  - state enum {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND}
  - localparams W, BIAS = 2^(EXP_W-1)-1, EXP_MAX = 2^EXP_W-1, SIG_W = MAN_W+4
  - canonical-qNaN constant function
  - class-code enum {ZERO, NORMAL, INF, NAN}
- Sub-module fp_lzc: parametrised combinational leading-zero counter over SIG_W+1 bits, output width clog2(SIG_W+2), instantiated in NORM.

Test Plan (defaults EXP_W=8, MAN_W=23):
- 0x3F800000 + 0x40000000, op=0 → result 0x40400000 at edge N+5, done single pulse, all flags 0, busy high for 5 cycles.
- 0x3F800000 − 0x3F800000 (op=1) → 0x00000000 (+0); 0x80000000 + 0x80000000 → 0x80000000.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, flag_invalid=1; 0x7FA00000 (sNaN) + 0x3F800000 → 0x7FC00000, flag_invalid=1.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flag_overflow=1, flag_inexact=1.
- Rounding ties:
  - 0x3F800000 + 0x33800000 → 0x3F800000, inexact=1 (tie to even, down).
  - 0x3F800000 + 0x34400000 → 0x3F800002, inexact=1 (tie to even, up).
- Handshake and reset:
  - Second start at N+2 → ignored, a single done.
  - reset asserted at N+3 → no done, outputs 0.
  - New start after reset → correct result 5 cycles later.
